// File: rtl/cluster_bus_axi_throttle_pkg.sv
// ============================================================================
// Package : cluster_bus_axi_throttle_pkg
// Brief   : Shared types and helpers for the cluster-bus AXI throttle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cluster_bus_axi_throttle_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } throttle_chan_state_e;

   localparam logic [0:0] C_ST_IDLE    = 1'b0;
   localparam logic [0:0] C_ST_PENDING = 1'b1;

   function automatic logic [1:0] commit_count(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

`default_nettype wire

// File: rtl/cluster_bus_axi_throttle_if.sv
// ============================================================================
// Interface : cluster_bus_axi_throttle_if
// Brief     : AW/AR valid-ready gating signals plus observed B/R handshakes.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cluster_bus_axi_throttle_if;
   logic slv_aw_valid;
   logic slv_aw_ready;
   logic mst_aw_valid;
   logic mst_aw_ready;
   logic slv_ar_valid;
   logic slv_ar_ready;
   logic mst_ar_valid;
   logic mst_ar_ready;
   logic b_valid;
   logic b_ready;
   logic r_valid;
   logic r_ready;
   logic r_last;

   // Throttle side
   modport slave (
      input  slv_aw_valid, mst_aw_ready, slv_ar_valid, mst_ar_ready,
      input  b_valid, b_ready, r_valid, r_ready, r_last,
      output slv_aw_ready, mst_aw_valid, slv_ar_ready, mst_ar_valid
   );

   // Crossbar/SoC environment side
   modport master (
      output slv_aw_valid, mst_aw_ready, slv_ar_valid, mst_ar_ready,
      output b_valid, b_ready, r_valid, r_ready, r_last,
      input  slv_aw_ready, mst_aw_valid, slv_ar_ready, mst_ar_valid
   );
endinterface

`default_nettype wire

// File: rtl/cluster_bus_axi_throttle_chan.sv
// ============================================================================
// Module  : cluster_bus_throttle_chan
// Brief   : One address channel: IDLE/PENDING gate, outstanding counter, cap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cluster_bus_throttle_chan
   import cluster_bus_axi_throttle_pkg::*;
#(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [CNT_W-1:0] max_i,
   input  logic             token_ok_i,
   input  logic             slv_valid_i,
   output logic             slv_ready_o,
   output logic             mst_valid_o,
   input  logic             mst_ready_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             idle_o,
   output logic             cap_ok_o,
   output logic             commit_o,
   output logic             stall_o,
   output logic             underflow_o
);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_idle;
   logic             w_cap_ok;
   logic             w_allow;
   logic             w_gate;
   logic             w_commit;

   assign w_idle   = (r_state == C_ST_IDLE);
   assign w_cap_ok = (max_i == '0) || (r_cnt < max_i);
   assign w_allow  = !en_i || (w_cap_ok && token_ok_i);
   // Once a request is committed the gate stays open so valid is never withdrawn
   assign w_gate   = !w_idle || w_allow;
   assign w_commit = w_idle && slv_valid_i && w_allow;

   assign mst_valid_o = slv_valid_i && w_gate;
   assign slv_ready_o = mst_ready_i && w_gate;
   assign stall_o     = w_idle && slv_valid_i && !w_allow;
   assign underflow_o = dec_i && !w_commit && (r_cnt == '0);
   assign commit_o    = w_commit;
   assign idle_o      = w_idle;
   assign cap_ok_o    = w_cap_ok;
   assign cnt_o       = r_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= C_ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            C_ST_IDLE:    if (w_commit && !mst_ready_i) r_state <= C_ST_PENDING;
            C_ST_PENDING: if (slv_valid_i && mst_ready_i) r_state <= C_ST_IDLE;
            default:      r_state <= C_ST_IDLE;
         endcase

         if (w_commit && !dec_i) begin
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
         end else if (dec_i && !w_commit) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cluster_bus_axi_throttle.sv
// ============================================================================
// Module  : cluster_bus_axi_throttle
// Brief   : Outstanding-cap and per-period burst-budget throttle for AW/AR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cluster_bus_axi_throttle
   import cluster_bus_axi_throttle_pkg::*;
#(
   parameter  int unsigned MAX_TXNS = 16,
   parameter  int unsigned PERIOD_W = 16,
   parameter  int unsigned BUDGET_W = 8,
   localparam int unsigned CNT_W    = $clog2(MAX_TXNS + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic [CNT_W-1:0]    max_rd_i,
   input  logic [CNT_W-1:0]    max_wr_i,
   input  logic [BUDGET_W-1:0] budget_i,
   input  logic [PERIOD_W-1:0] period_i,
   cluster_bus_axi_throttle_if.slave bus,
   output logic [CNT_W-1:0]    wr_outstanding_o,
   output logic [CNT_W-1:0]    rd_outstanding_o,
   output logic                stall_o,
   output logic                err_o
);

   logic [PERIOD_W-1:0] r_period_cnt;
   logic [PERIOD_W-1:0] w_period_last;
   logic [BUDGET_W-1:0] r_tokens;
   logic [BUDGET_W-1:0] w_token_eff;
   logic [BUDGET_W-1:0] w_tokens_nxt;
   logic [1:0]          w_commits;
   logic                r_prio;
   logic                r_err;
   logic                w_token_ok;
   logic                w_contend;
   logic                w_tok_ok_aw, w_tok_ok_ar;
   logic                w_aw_idle, w_ar_idle;
   logic                w_aw_cap_ok, w_ar_cap_ok;
   logic                w_aw_commit, w_ar_commit;
   logic                w_aw_stall, w_ar_stall;
   logic                w_aw_uf, w_ar_uf;
   logic                w_b_hs, w_r_last_hs;

   assign w_b_hs      = bus.b_valid && bus.b_ready;
   assign w_r_last_hs = bus.r_valid && bus.r_ready && bus.r_last;

   assign w_period_last = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
   assign w_token_eff   = (r_period_cnt == '0) ? budget_i : r_tokens;
   assign w_token_ok    = (budget_i == '0) || (w_token_eff != '0);

   // A single remaining token with both channels ready to commit goes to one side only
   assign w_contend = en_i && (budget_i != '0) && (w_token_eff == BUDGET_W'(1)) &&
                      w_aw_idle && w_ar_idle && bus.slv_aw_valid && bus.slv_ar_valid &&
                      w_aw_cap_ok && w_ar_cap_ok;
   assign w_tok_ok_ar = w_token_ok && !(w_contend && r_prio);
   assign w_tok_ok_aw = w_token_ok && !(w_contend && !r_prio);

   assign w_commits    = commit_count(w_aw_commit, w_ar_commit);
   assign w_tokens_nxt = (w_token_eff > BUDGET_W'(w_commits)) ?
                         w_token_eff - BUDGET_W'(w_commits) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_period_cnt <= '0;
         r_tokens     <= '0;
         r_prio       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_period_cnt <= (r_period_cnt >= w_period_last) ? '0 : r_period_cnt + PERIOD_W'(1);
         r_tokens     <= w_tokens_nxt;
         if (w_contend) r_prio <= !r_prio;
         r_err        <= r_err || w_aw_uf || w_ar_uf;
      end
   end

   cluster_bus_throttle_chan #(.CNT_W(CNT_W)) u_aw_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .max_i       (max_wr_i),
      .token_ok_i  (w_tok_ok_aw),
      .slv_valid_i (bus.slv_aw_valid),
      .slv_ready_o (bus.slv_aw_ready),
      .mst_valid_o (bus.mst_aw_valid),
      .mst_ready_i (bus.mst_aw_ready),
      .dec_i       (w_b_hs),
      .cnt_o       (wr_outstanding_o),
      .idle_o      (w_aw_idle),
      .cap_ok_o    (w_aw_cap_ok),
      .commit_o    (w_aw_commit),
      .stall_o     (w_aw_stall),
      .underflow_o (w_aw_uf)
   );

   cluster_bus_throttle_chan #(.CNT_W(CNT_W)) u_ar_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .max_i       (max_rd_i),
      .token_ok_i  (w_tok_ok_ar),
      .slv_valid_i (bus.slv_ar_valid),
      .slv_ready_o (bus.slv_ar_ready),
      .mst_valid_o (bus.mst_ar_valid),
      .mst_ready_i (bus.mst_ar_ready),
      .dec_i       (w_r_last_hs),
      .cnt_o       (rd_outstanding_o),
      .idle_o      (w_ar_idle),
      .cap_ok_o    (w_ar_cap_ok),
      .commit_o    (w_ar_commit),
      .stall_o     (w_ar_stall),
      .underflow_o (w_ar_uf)
   );

   assign stall_o = w_aw_stall || w_ar_stall;
   assign err_o   = r_err;

endmodule

`default_nettype wire
